// File: rtl/cr_kme_fifo_arb.sv
// cr_kme_fifo_arb: round-robin arbiter that lets N_REQ packet sources share
// one 256-bit FIFO write port. A grant is locked for a whole packet (until a
// beat carrying req_last transfers, or MAX_BEATS beats transfer). Arbitration
// takes one IDLE cycle and ignores FIFO backpressure. Overflow and over-length
// conditions are latched as sticky error flags.
module cr_kme_fifo_arb #(
  parameter int N_REQ     = 4,
  parameter int MAX_BEATS = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*256-1:0]   req_data,
  input  logic [N_REQ-1:0]       req_last,
  output logic [N_REQ-1:0]       req_ready,
  output logic [255:0]           fifo_in,
  output logic                   fifo_in_valid,
  input  logic                   fifo_in_stall,
  input  logic                   fifo_overflow,
  output logic [2:0]             grant_id,
  output logic                   busy,
  output logic                   err_len,
  output logic                   err_ovf
);

  localparam int DATA_W = 256;
  localparam int CNT_W  = (MAX_BEATS < 2) ? 1 : $clog2(MAX_BEATS + 1);

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_e;

  state_e             state_q;
  logic [2:0]         rr_ptr_q;
  logic [2:0]         grant_q;
  logic [CNT_W-1:0]   beat_cnt_q;
  logic               err_len_q;
  logic               err_ovf_q;

  logic [2:0]         winner;
  logic               any_req;
  logic               own_valid;
  logic               own_last;
  logic               beat_fire;
  logic               at_max;
  logic               pkt_end;
  logic               len_err;
  logic [2:0]         rr_ptr_d;
  logic [CNT_W-1:0]   beat_cnt_d;

  // Round-robin pick: the valid requester closest above rr_ptr (with wrap) wins.
  always_comb begin
    int best_off;
    int off;
    winner   = rr_ptr_q;
    any_req  = |req_valid;
    best_off = N_REQ;
    off      = 0;
    for (int i = 0; i < N_REQ; i++) begin
      off = i - int'(rr_ptr_q);
      if (off < 0) off = off + N_REQ;
      if (req_valid[i] && (off < best_off)) begin
        best_off = off;
        winner   = 3'(i);
      end
    end
  end

  // Route the owner's valid/last/data onto the FIFO side.
  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    fifo_in   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q == 3'(i)) begin
        own_valid = req_valid[i];
        own_last  = req_last[i];
        fifo_in   = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // A beat moves only while owning the port and the FIFO has room.
  always_comb begin
    beat_fire     = (state_q == XFER) && own_valid && !fifo_in_stall;
    fifo_in_valid = beat_fire;
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i] = beat_fire && (grant_q == 3'(i));
    end
    at_max     = (beat_cnt_q == CNT_W'(MAX_BEATS - 1));
    pkt_end    = beat_fire && (own_last || at_max);
    len_err    = beat_fire && !own_last && at_max;
    rr_ptr_d   = (grant_q == 3'(N_REQ - 1)) ? 3'd0 : (grant_q + 3'd1);
    beat_cnt_d = beat_cnt_q + CNT_W'(1);
  end

  // Arbitration FSM with packet lock, beat counting and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= 3'd0;
      grant_q    <= 3'd0;
      beat_cnt_q <= '0;
      err_len_q  <= 1'b0;
      err_ovf_q  <= 1'b0;
    end else begin
      if (fifo_overflow) err_ovf_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            grant_q    <= winner;
            beat_cnt_q <= '0;
            state_q    <= XFER;
          end
        end
        XFER: begin
          if (pkt_end) begin
            state_q  <= IDLE;
            rr_ptr_q <= rr_ptr_d;
            if (len_err) err_len_q <= 1'b1;
          end else if (beat_fire) begin
            beat_cnt_q <= beat_cnt_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = (state_q == XFER);
  assign grant_id = grant_q;
  assign err_len  = err_len_q;
  assign err_ovf  = err_ovf_q;

endmodule
